ram32x4_access_sched: RTL and testbench

Access scheduler for the single-port 32x4 RAM in the lab designs. It shares the one RAM port between three requesters: a clear engine that zero-fills memory, a host write port (switch/key driven), and a periodic display scanner paced by a slow tick. It sits between those requesters and the RAM macro, and it owns the RAM address, write-data and write-enable lines.

---
 rtl/ram_sched_pkg.sv | 23 ++
 rtl/ram_sched_ptr.sv | 26 ++
 rtl/ram32x4_access_sched.sv | 155 +++++++++++++++
 tb/tb_ram32x4_access_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sched_pkg.sv
// Shared types and defaults for the 32x4 RAM access scheduler.
// Used by the RTL and by the bench scoreboard.
package ram_sched_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WDONE,
        RD_ADDR,
        RD_CAP
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CLR,
        GNT_WR,
        GNT_SCAN
    } gnt_t;

endpackage

// File: rtl/ram_sched_ptr.sv
// Modulo-DEPTH up-counter with synchronous load-zero and enable.
// Serves as the clear address and the scan pointer.
module ram_sched_ptr
    import ram_sched_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              zero,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt
);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            cnt <= '0;
        end else if (zero) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == ADDR_W'(DEPTH - 1)) ? '0 : cnt + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram32x4_access_sched.sv
// Shares the single RAM port between the clear engine,
// the host write port and the periodic display scanner.
module ram32x4_access_sched
    import ram_sched_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              clr_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              scan_tick,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state;
    gnt_t              gnt;
    logic              clr_pend;
    logic              scan_pend;
    logic              last_wr;
    logic              clr_last;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] scan_ptr;

    // The clear counter has wrapped back to 0 once the last word is issued.
    assign clr_last = (state == CLEAR) && (clr_cnt == '0);

    // A clr_req on the same edge holds the port so the clear goes first.
    always_comb begin
        gnt = GNT_NONE;
        if (state == IDLE) begin
            if (clr_pend) begin
                gnt = GNT_CLR;
            end else if (!clr_req) begin
                if (wr_req && !(last_wr && scan_pend)) begin
                    gnt = GNT_WR;
                end else if (scan_pend) begin
                    gnt = GNT_SCAN;
                end
            end
        end
    end

    ram_sched_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr_ptr (
        .clk  (clk),
        .aclr (aclr),
        .zero (clr_last),
        .en   ((gnt == GNT_CLR) || ((state == CLEAR) && !clr_last)),
        .cnt  (clr_cnt)
    );

    ram_sched_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_scan_ptr (
        .clk  (clk),
        .aclr (aclr),
        .zero (clr_last),
        .en   (state == RD_CAP),
        .cnt  (scan_ptr)
    );

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state      <= IDLE;
            clr_pend   <= 1'b0;
            scan_pend  <= 1'b0;
            last_wr    <= 1'b0;
            wr_ack     <= 1'b0;
            scan_addr  <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
            busy       <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            wr_ack     <= 1'b0;
            scan_valid <= 1'b0;
            if (clr_req && (state != CLEAR)) begin
                clr_pend <= 1'b1;
            end
            if (scan_tick) begin
                scan_pend <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    unique case (gnt)
                        GNT_CLR: begin
                            state     <= CLEAR;
                            busy      <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_addr  <= clr_cnt;
                            ram_wdata <= '0;
                            last_wr   <= 1'b0;
                        end
                        GNT_WR: begin
                            state     <= WDONE;
                            ram_we    <= 1'b1;
                            ram_addr  <= wr_addr;
                            ram_wdata <= wr_data;
                            wr_ack    <= 1'b1;
                            last_wr   <= 1'b1;
                        end
                        GNT_SCAN: begin
                            state     <= RD_ADDR;
                            ram_addr  <= scan_ptr;
                            scan_pend <= scan_tick;
                            last_wr   <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                CLEAR: begin
                    if (clr_last) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_pend <= 1'b0;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_addr  <= clr_cnt;
                        ram_wdata <= '0;
                    end
                end
                WDONE: begin
                    state <= IDLE;
                end
                RD_ADDR: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    state      <= IDLE;
                    scan_data  <= ram_q;
                    scan_addr  <= scan_ptr;
                    scan_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram32x4_access_sched.sv
// Scoreboard bench for ram32x4_access_sched with a behavioural
// synchronous-read RAM attached to the scheduler's port.
module tb_ram32x4_access_sched;
    import ram_sched_pkg::*;

    typedef struct {
        gnt_t       kind;
        logic [4:0] addr;
        logic [3:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       aclr;
    logic       clr_req;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       scan_tick;
    logic [4:0] scan_addr;
    logic [3:0] scan_data;
    logic       scan_valid;
    logic       busy;
    logic [4:0] ram_addr;
    logic [3:0] ram_wdata;
    logic       ram_we;
    logic [3:0] ram_q;

    logic [3:0] mem [32];
    logic       pre;
    int         cyc = 0;
    int         n_run = 0;
    int         n_fail = 0;
    int         bcnt = 0;
    ev_t        q[$];

    ram32x4_access_sched dut (
        .clk        (clk),
        .aclr       (aclr),
        .clr_req    (clr_req),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .scan_tick  (scan_tick),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 32; i++) mem[i] <= 4'(i) ^ 4'hC;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void push(gnt_t k, int a, int d, int cy);
        q.push_back('{k, 5'(a), 4'(d), cy});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_cycle();
        gnt_t       k;
        logic [4:0] a;
        logic [3:0] d;
        ev_t        e;
        if (!aclr) begin
            bcnt = 0;
            return;
        end
        if (ram_we || scan_valid) begin
            k = ram_we ? (busy ? GNT_CLR : GNT_WR) : GNT_SCAN;
            a = ram_we ? ram_addr : scan_addr;
            d = ram_we ? ram_wdata : scan_data;
            if (q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL spurious: got kind %0d addr %0d data %0h, expected none (cyc %0d)",
                         k, a, d, cyc);
            end else begin
                e = q.pop_front();
                chk("event{kind,addr,data}", int'({k, a, d}),
                    int'({e.kind, e.addr, e.data}));
                chk("wr_ack_with_event", int'(wr_ack), int'(k == GNT_WR));
                if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
            end
        end else if (wr_ack) begin
            chk("wr_ack_without_write", int'(wr_ack), 0);
        end
        if (busy) begin
            bcnt++;
        end else if (bcnt != 0) begin
            chk("busy_length", bcnt, 32);
            bcnt = 0;
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && q.size() != 0; i++) step(1);
        step(6);
        chk(nm, q.size(), 0);
    endtask

    task automatic tick_scan(input int a, input int d);
        push(GNT_SCAN, a, d, cyc + 4);
        scan_tick = 1'b1;
        step(1);
        scan_tick = 1'b0;
        step(7);
    endtask

    initial begin
        int c;
        int t;
        aclr = 1'b0;
        pre = 1'b1;
        clr_req = 1'b0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        scan_tick = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon_cycle();
            end
        join_none

        step(3);
        chk("reset_outputs", int'({wr_ack, scan_addr, scan_data, scan_valid,
            busy, ram_addr, ram_wdata, ram_we}), 0);
        pre = 1'b0;
        aclr = 1'b1;
        step(1);

        // Reset in the middle of a clear: words 10.. keep old contents.
        c = cyc;
        for (int i = 0; i < 10; i++) push(GNT_CLR, i, 0, c + 2 + i);
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0;
        t = 0;
        while (!(busy && ram_addr == 5'd10) && t < 40) begin
            step(1);
            t++;
        end
        chk("reach_clear_cycle_10", int'(busy && ram_addr == 5'd10), 1);
        aclr = 1'b0;
        #1;
        chk("reset_mid_clear_outputs", int'({wr_ack, scan_addr, scan_data,
            scan_valid, busy, ram_addr, ram_wdata, ram_we}), 0);
        step(2);
        aclr = 1'b1;
        step(1);
        chk("queue_after_abort", q.size(), 0);
        for (int i = 0; i < 11; i++) tick_scan(i, (i == 10) ? 6 : 0);
        drain("drain_abort_scans");

        // Single write with wr_req held one extra cycle.
        push(GNT_WR, 7, 4'hA, cyc + 1);
        wr_addr = 5'h07;
        wr_data = 4'hA;
        wr_req = 1'b1;
        step(2);
        wr_req = 1'b0;
        drain("drain_single_write");

        // Full clear; a second request mid-clear is ignored.
        c = cyc;
        for (int i = 0; i < 32; i++) push(GNT_CLR, i, 0, c + 2 + i);
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0;
        step(6);
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0;
        drain("drain_clear");

        // Scan wrap after the clear.
        for (int i = 0; i < 33; i++) tick_scan(i % 32, 0);
        drain("drain_scan_wrap");

        // Contention: writes and scans must alternate.
        for (int k = 0; k < 6; k++) begin
            push(GNT_WR, 24 + k, k + 1, -1);
            push(GNT_SCAN, 1 + k, 0, -1);
        end
        fork
            begin
                wr_addr = 5'd24;
                wr_data = 4'd1;
                wr_req = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    int w;
                    w = 0;
                    do begin
                        step(1);
                        w++;
                    end while (!wr_ack && w < 20);
                    chk("contention_ack_seen", int'(wr_ack), 1);
                    wr_addr = 5'(25 + k);
                    wr_data = 4'(k + 2);
                    if (k == 5) wr_req = 1'b0;
                end
                wr_req = 1'b0;
            end
            begin
                for (int i = 0; i < 7; i++) begin
                    scan_tick = 1'b1;
                    step(1);
                    scan_tick = 1'b0;
                    step(3);
                end
            end
        join
        drain("drain_contention");

        // Clear, write and tick on the same edge.
        c = cyc;
        for (int i = 0; i < 32; i++) push(GNT_CLR, i, 0, c + 2 + i);
        push(GNT_WR, 3, 5, c + 35);
        push(GNT_SCAN, 0, 0, c + 39);
        clr_req = 1'b1;
        wr_addr = 5'd3;
        wr_data = 4'd5;
        wr_req = 1'b1;
        scan_tick = 1'b1;
        step(1);
        clr_req = 1'b0;
        scan_tick = 1'b0;
        t = 0;
        while (!wr_ack && t < 60) begin
            step(1);
            t++;
        end
        chk("simul_ack_seen", int'(wr_ack), 1);
        wr_req = 1'b0;
        drain("drain_simultaneous");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
